// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin arbiter feeding two requesters into one UART transmitter.
module tx_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req0_valid,
  input  logic                  req1_valid,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req0_ack,
  output logic                  req1_ack,
  input  logic                  tx_busy,
  output logic                  tx_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic [1:0]            grant,
  output logic                  arb_busy,
  output logic                  err_timeout
);
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LAUNCH    = 2'd1;
  localparam logic [1:0] WAIT_BUSY = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;
  logic [1:0] state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic       last_grant, go, win1, timeout_hit;
  // last_grant is 1 when req1 won last, so a tie goes to req0
  always_comb begin
    go          = state == IDLE && !tx_busy && (req0_valid || req1_valid);
    win1        = req1_valid && (!req0_valid || !last_grant);
    timeout_hit = state == WAIT_BUSY && !tx_busy && cnt == 4'(TIMEOUT - 1);
    state_nx    = state == IDLE      ? (go ? LAUNCH : IDLE) :
                  state == LAUNCH    ? WAIT_BUSY :
                  state == WAIT_BUSY ? (tx_busy ? WAIT_DONE : timeout_hit ? IDLE : WAIT_BUSY) :
                                       (tx_busy ? WAIT_DONE : IDLE);
    cnt_nx      = state == WAIT_BUSY && state_nx == WAIT_BUSY ? (&cnt ? cnt : cnt + 4'd1) : 4'd0;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      last_grant  <= 1'b1;
      tx_valid    <= 1'b0;
      tx_data     <= '0;
      grant       <= 2'b00;
      arb_busy    <= 1'b0;
      req0_ack    <= 1'b0;
      req1_ack    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      tx_valid    <= go;
      req0_ack    <= go && !win1;
      req1_ack    <= go && win1;
      err_timeout <= timeout_hit;
      arb_busy    <= state_nx != IDLE;
      grant       <= go ? {win1, !win1} : state_nx == IDLE ? 2'b00 : grant;
      if (go) begin
        tx_data    <= win1 ? req1_data : req0_data;
        last_grant <= win1;
      end
    end
  end
endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: directed scenarios plus randomized traffic checked against a transaction-level model.
module tb_tx_arbiter;
  localparam int DW = 8;
  localparam int TO = 4;
  logic          CLK = 0, RST = 0, req0_valid = 0, req1_valid = 0, tx_busy = 0;
  logic [DW-1:0] req0_data = '0, req1_data = '0, tx_data;
  logic          req0_ack, req1_ack, tx_valid, arb_busy, err_timeout;
  logic [1:0]    grant;
  int            n_cmp = 0, n_bad = 0, cyc = 0;

  tx_arbiter #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_data(req0_data), .req1_data(req1_data),
    .req0_ack(req0_ack), .req1_ack(req1_ack),
    .tx_busy(tx_busy), .tx_valid(tx_valid), .tx_data(tx_data),
    .grant(grant), .arb_busy(arb_busy), .err_timeout(err_timeout)
  );

  always #5 CLK = ~CLK;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic tick;
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic do_reset;
    RST = 1; req0_valid = 0; req1_valid = 0; tx_busy = 0;
    tick;
    tick;
    RST = 0;
  endtask

  task automatic wait_tx(input int lim, input string tag);
    int n = 0;
    while (tx_valid !== 1'b1 && n < lim) begin
      tick;
      n++;
    end
    n_cmp++;
    if (tx_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL %s: tx_valid=%b after %0d cycles, required 1", tag, tx_valid, lim);
    end
  endtask

  task automatic test_reset;
    RST = 0;
    #1;
    RST = 1;
    #2;
    n_cmp++;
    if ({tx_valid, tx_data, grant, arb_busy, req0_ack, req1_ack, err_timeout} !== 15'd0) begin
      n_bad++;
      $display("FAIL reset_async: outputs=%h required 0", {tx_valid, tx_data, grant, arb_busy, req0_ack, req1_ack, err_timeout});
    end
    tick;
    n_cmp++;
    if ({tx_valid, tx_data, grant, arb_busy, req0_ack, req1_ack, err_timeout} !== 15'd0) begin
      n_bad++;
      $display("FAIL reset_held: outputs=%h required 0", {tx_valid, tx_data, grant, arb_busy, req0_ack, req1_ack, err_timeout});
    end
    RST = 0;
    tick;
    n_cmp++;
    if ({tx_valid, grant, arb_busy, req0_ack, req1_ack, err_timeout} !== 7'd0) begin
      n_bad++;
      $display("FAIL reset_idle: outputs=%h required 0", {tx_valid, grant, arb_busy, req0_ack, req1_ack, err_timeout});
    end
  endtask

  task automatic test_single;
    req0_valid = 1; req0_data = 8'hA5;
    wait_tx(10, "single_launch");
    n_cmp++;
    if ({req0_ack, req1_ack, tx_data, grant} !== {1'b1, 1'b0, 8'hA5, 2'b01}) begin
      n_bad++;
      $display("FAIL single_capture: ack0=%b ack1=%b data=%h grant=%b required 1 0 a5 01", req0_ack, req1_ack, tx_data, grant);
    end
    req0_valid = 0;
    for (int i = 1; i <= 11; i++) begin
      tick;
      tx_busy = i <= 10;
      n_cmp++;
      if ({tx_valid, req0_ack, req1_ack, grant, arb_busy, tx_data} !== {3'b000, 2'b01, 1'b1, 8'hA5}) begin
        n_bad++;
        $display("FAIL single_hold[%0d]: txv=%b acks=%b%b grant=%b busy=%b data=%h required 0 00 01 1 a5", i, tx_valid, req0_ack, req1_ack, grant, arb_busy, tx_data);
      end
    end
    tick;
    n_cmp++;
    if ({arb_busy, grant, tx_data} !== {1'b0, 2'b00, 8'hA5}) begin
      n_bad++;
      $display("FAIL single_release: busy=%b grant=%b data=%h required 0 00 a5", arb_busy, grant, tx_data);
    end
  endtask

  task automatic test_tie;
    logic [DW-1:0] exp_d[4] = '{8'h11, 8'h22, 8'h11, 8'h22};
    do_reset;
    req0_valid = 1; req0_data = 8'h11;
    req1_valid = 1; req1_data = 8'h22;
    for (int k = 0; k < 4; k++) begin
      wait_tx(10, "tie_launch");
      n_cmp++;
      if ({tx_data, req0_ack, req1_ack, grant} !== {exp_d[k], k % 2 == 0, k % 2 == 1, k % 2 == 1 ? 2'b10 : 2'b01}) begin
        n_bad++;
        $display("FAIL tie[%0d]: data=%h acks=%b%b grant=%b required data %h", k, tx_data, req0_ack, req1_ack, grant, exp_d[k]);
      end
      tick;
      tx_busy = 1;
      tick;
      tx_busy = 0;
    end
    req0_valid = 0; req1_valid = 0;
    tick;
    tick;
  endtask

  task automatic test_timeout;
    logic [DW-1:0] d1 = DW'($urandom), d0 = DW'($urandom);
    int n = 0;
    do_reset;
    req1_valid = 1; req1_data = d1;
    wait_tx(10, "timeout_launch");
    n_cmp++;
    if ({tx_data, req1_ack, grant} !== {d1, 1'b1, 2'b10}) begin
      n_bad++;
      $display("FAIL timeout_capture: data=%h ack1=%b grant=%b required %h 1 10", tx_data, req1_ack, grant, d1);
    end
    req1_valid = 0;
    do begin
      tick;
      n++;
    end while (err_timeout !== 1'b1 && n < 20);
    n_cmp++;
    if (n != TO + 1 || arb_busy !== 1'b0 || grant !== 2'b00) begin
      n_bad++;
      $display("FAIL timeout_abort: err after %0d cycles busy=%b grant=%b required %0d 0 00", n, arb_busy, grant, TO + 1);
    end
    req0_valid = 1; req0_data = d0;
    tick;
    n_cmp++;
    if (err_timeout !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_pulse: err_timeout=%b required 0", err_timeout);
    end
    wait_tx(10, "timeout_next");
    n_cmp++;
    if ({tx_data, req0_ack} !== {d0, 1'b1}) begin
      n_bad++;
      $display("FAIL timeout_next: data=%h ack0=%b required %h 1", tx_data, req0_ack, d0);
    end
    req0_valid = 0;
    tick;
    tx_busy = 1;
    tick;
    tx_busy = 0;
    tick;
    tick;
  endtask

  task automatic test_busy_block;
    logic [DW-1:0] d1 = DW'($urandom);
    do_reset;
    tx_busy = 1;
    req1_valid = 1; req1_data = d1;
    for (int i = 0; i < 5; i++) begin
      tick;
      n_cmp++;
      if ({tx_valid, req0_ack, req1_ack, arb_busy, grant} !== 6'd0) begin
        n_bad++;
        $display("FAIL busy_block[%0d]: txv=%b acks=%b%b busy=%b grant=%b required all 0", i, tx_valid, req0_ack, req1_ack, arb_busy, grant);
      end
    end
    tx_busy = 0;
    tick;
    n_cmp++;
    if ({tx_valid, req1_ack, grant, tx_data} !== {1'b1, 1'b1, 2'b10, d1}) begin
      n_bad++;
      $display("FAIL busy_release: txv=%b ack1=%b grant=%b data=%h required 1 1 10 %h", tx_valid, req1_ack, grant, tx_data, d1);
    end
    req1_valid = 0;
    tick;
    tx_busy = 1;
    tick;
    tx_busy = 0;
    tick;
    tick;
  endtask

  task automatic test_reset_mid;
    logic [DW-1:0] d0 = DW'($urandom);
    int acks = 0;
    do_reset;
    req0_valid = 1; req0_data = d0;
    wait_tx(10, "rstmid_launch");
    tick;
    tx_busy = 1;
    tick;
    #2;
    RST = 1;
    tx_busy = 0;
    #1;
    n_cmp++;
    if ({tx_valid, tx_data, grant, arb_busy, req0_ack, req1_ack, err_timeout} !== 15'd0) begin
      n_bad++;
      $display("FAIL rstmid_async: outputs=%h required 0", {tx_valid, tx_data, grant, arb_busy, req0_ack, req1_ack, err_timeout});
    end
    for (int i = 0; i < 2; i++) begin
      tick;
      n_cmp++;
      if ({tx_valid, grant, arb_busy, req0_ack, req1_ack} !== 6'd0) begin
        n_bad++;
        $display("FAIL rstmid_held[%0d]: txv=%b grant=%b busy=%b acks=%b%b required all 0", i, tx_valid, grant, arb_busy, req0_ack, req1_ack);
      end
    end
    RST = 0;
    tick;
    n_cmp++;
    if ({tx_valid, req0_ack, tx_data} !== {1'b1, 1'b1, d0}) begin
      n_bad++;
      $display("FAIL rstmid_rearb: txv=%b ack0=%b data=%h required 1 1 %h", tx_valid, req0_ack, tx_data, d0);
    end
    acks = int'(req0_ack);
    req0_valid = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      acks += int'(req0_ack);
    end
    n_cmp++;
    if (acks != 1) begin
      n_bad++;
      $display("FAIL rstmid_ack_count: %0d acks, required 1", acks);
    end
  endtask

  task automatic test_back_to_back;
    int lc[4];
    do_reset;
    req0_valid = 1; req0_data = DW'($urandom);
    for (int k = 0; k < 4; k++) begin
      wait_tx(10, "b2b_launch");
      lc[k] = cyc;
      tick;
      tx_busy = 1;
      tick;
      tx_busy = 0;
    end
    req0_valid = 0;
    for (int k = 1; k < 4; k++) begin
      n_cmp++;
      if (lc[k] - lc[k-1] != 4) begin
        n_bad++;
        $display("FAIL b2b_period[%0d]: %0d cycles, required 4", k, lc[k] - lc[k-1]);
      end
    end
    tick;
    tick;
  endtask

  task automatic test_random;
    logic [DW-1:0] q0[$], q1[$], expd;
    int total, served = 0, free_at, err_at = -1, bs = -1, be = -2, start, d, n;
    bit lastg = 1, pv0 = 0, pv1 = 0, exp_tx, w;
    do_reset;
    repeat ($urandom_range(10, 5)) q0.push_back(DW'($urandom));
    repeat ($urandom_range(10, 5)) q1.push_back(DW'($urandom));
    total = q0.size() + q1.size();
    free_at = cyc;
    start = cyc;
    while (cyc - start < 2000 && !(q0.size() == 0 && q1.size() == 0 && cyc >= free_at)) begin
      if (!req0_valid && q0.size() > 0 && $urandom_range(1, 0) == 1) begin
        req0_valid = 1; req0_data = q0[0];
      end
      if (!req1_valid && q1.size() > 0 && $urandom_range(1, 0) == 1) begin
        req1_valid = 1; req1_data = q1[0];
      end
      tx_busy = cyc >= bs && cyc <= be;
      pv0 = req0_valid;
      pv1 = req1_valid;
      tick;
      exp_tx = cyc - 1 >= free_at && (pv0 || pv1);
      n_cmp++;
      if (tx_valid !== exp_tx) begin
        n_bad++;
        $display("FAIL rnd_launch@%0d: tx_valid=%b required %b", cyc, tx_valid, exp_tx);
      end
      n_cmp++;
      if (err_timeout !== (cyc == err_at)) begin
        n_bad++;
        $display("FAIL rnd_err@%0d: err_timeout=%b required %b", cyc, err_timeout, cyc == err_at);
      end
      if (exp_tx) begin
        w = pv0 && pv1 ? !lastg : pv1;
        expd = w ? q1[0] : q0[0];
        n_cmp++;
        if ({tx_data, req0_ack, req1_ack, grant} !== {expd, !w, w, w ? 2'b10 : 2'b01}) begin
          n_bad++;
          $display("FAIL rnd_word@%0d: data=%h acks=%b%b grant=%b required %h winner req%0d", cyc, tx_data, req0_ack, req1_ack, grant, expd, w);
        end
        if (w) begin
          void'(q1.pop_front());
          req1_valid = 0;
        end else begin
          void'(q0.pop_front());
          req0_valid = 0;
        end
        lastg = w;
        served++;
        if ($urandom_range(4, 0) == 0) begin
          err_at = cyc + 1 + TO; free_at = err_at; bs = -1; be = -2;
        end else begin
          d = $urandom_range(TO - 1, 0);
          n = $urandom_range(4, 1);
          bs = cyc + 1 + d; be = cyc + d + n; free_at = cyc + 2 + d + n;
        end
      end else begin
        n_cmp++;
        if ({req0_ack, req1_ack} !== 2'b00) begin
          n_bad++;
          $display("FAIL rnd_ack@%0d: acks=%b%b required 00", cyc, req0_ack, req1_ack);
        end
      end
    end
    n_cmp++;
    if (served != total || q0.size() + q1.size() != 0) begin
      n_bad++;
      $display("FAIL rnd_total: served %0d of %0d words, required all", served, total);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_tie;
    test_timeout;
    test_busy_block;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/tx_arbiter.md
TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of each requester word and of tx_data.
REQ-002 Parameter TIMEOUT, default 4, maximum number of cycles spent in WAIT_BUSY before aborting; legal range 2..15.
REQ-003 CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 req0_valid, req1_valid  input  1 each  the requester holds a word for transmission.
REQ-006 req0_data, req1_data  input  DATA_WIDTH each  requester words; held stable while the matching valid is high.
REQ-007 req0_ack, req1_ack  output  1 each  one-cycle pulse; the word has been captured.
REQ-008 tx_busy  input  1  busy flag from the UART transmitter.
REQ-009 tx_valid  output  1  one-cycle launch strobe to the UART transmitter.
REQ-010 tx_data  output  DATA_WIDTH  captured word; held stable from LAUNCH through WAIT_DONE.
REQ-011 grant  output  2  one-hot current owner (bit0 = req0); 2'b00 in IDLE.
REQ-012 arb_busy  output  1  high in every state except IDLE.
REQ-013 err_timeout  output  1  one-cycle pulse when the transmitter never asserted busy.

Function
REQ-014 FSM states SHALL be IDLE, LAUNCH, WAIT_BUSY and WAIT_DONE; all outputs SHALL be registered.
REQ-015 IDLE SHALL start arbitration only when tx_busy==0 and at least one reqN_valid==1; otherwise IDLE SHALL hold.
REQ-016 A single valid requester SHALL win.
REQ-017 If both requesters are valid in the same cycle, the requester not granted last SHALL win (round-robin via a last_grant register).
REQ-018 On the winning edge (IDLE->LAUNCH), the following SHALL occur together:
- tx_data loads the winner's data;
- grant sets the winner's bit;
- reqN_ack is high for exactly the LAUNCH cycle;
- last_grant updates.
REQ-019 A requester SHALL hold valid and data until it sees ack; the arbiter SHALL NOT sample a requester again before returning to IDLE.
REQ-020 LAUNCH SHALL drive tx_valid=1 for exactly one cycle, then SHALL move to WAIT_BUSY with the timeout counter cleared.
REQ-021 WAIT_BUSY, tx_busy==1: the next state SHALL be WAIT_DONE.
REQ-022 WAIT_BUSY, tx_busy==0: the counter SHALL increment; when the counter reaches TIMEOUT-1 with tx_busy still 0, the next state SHALL be IDLE and err_timeout SHALL pulse for one cycle in the first IDLE cycle.
REQ-023 WAIT_DONE SHALL hold while tx_busy==1 and SHALL move to IDLE on the first cycle tx_busy==0.
REQ-024 On returning to IDLE, grant SHALL be 2'b00; tx_data SHALL retain its last value.
REQ-025 Minimum spacing between two tx_valid pulses SHALL be 4 cycles (LAUNCH, WAIT_BUSY, WAIT_DONE, IDLE).
REQ-026 The timeout counter SHALL be 4 bits wide, SHALL saturate rather than wrap, and SHALL clear in every state other than WAIT_BUSY.
REQ-027 Illegal state encodings SHALL recover to IDLE on the next edge with all outputs at reset values.
REQ-028 A reqN_valid drop before ack (protocol violation) SHALL NOT corrupt the FSM; the arbiter SHALL only use values sampled in IDLE.

Reset
REQ-029 While RST=1, regardless of CLK, the following SHALL hold immediately:
- state=IDLE;
- tx_valid=0, tx_data=0, grant=2'b00, arb_busy=0;
- req0_ack=req1_ack=0, err_timeout=0;
- counter=0;
- last_grant=req1, so req0 wins the first tie.
REQ-030 Reset asserted mid-transfer SHALL abort with no tx_valid or ack pulse after release; arbitration SHALL restart from IDLE on the first edge with RST=0.

Verification
REQ-031 Single request: req0_valid=1, data=8'hA5; tx_busy rises 1 cycle after tx_valid and stays high 10 cycles -> req0_ack and tx_valid pulse once, tx_data=8'hA5, grant=01 throughout, arb_busy falls 1 cycle after tx_busy falls.
REQ-032 Tie after reset: both valid with 8'h11/8'h22 held -> tx_data order 11,22,11,22; acks alternate; no word is lost or duplicated.
REQ-033 Timeout with TIMEOUT=4: tx_busy stuck at 0 -> exactly 4 WAIT_BUSY cycles, then IDLE with err_timeout=1 for one cycle; next request is still served.
REQ-034 Transmitter busy from another source: tx_busy=1 in IDLE with req1_valid=1 -> no ack and no tx_valid until tx_busy=0, then grant=10 on the next edge.
REQ-035 Reset in WAIT_DONE: RST pulsed for 2 cycles -> outputs are zero asynchronously; after release, the held req0_valid is re-arbitrated and acked once.
REQ-036 Back-to-back req0 only, busy 1 cycle: tx_valid period is exactly 4 cycles.
